// File: rtl/weight_buffer_mb.sv
// weight_buffer_mb: byte-masked weight row buffer with a frozen-on-stall read
// pipeline, single-row reads and a wrapping sequential burst reader.
module weight_buffer_mb #(
    parameter int  MATRIX_WIDTH = 14,
    parameter int  BYTE_WIDTH   = 8,
    parameter int  DEPTH        = 32768,
    parameter int  READ_LATENCY = 2,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [MATRIX_WIDTH-1:0]            wr_mask,
    input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] wr_data,
    input  logic                               rd_en,
    input  logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic                               burst_start,
    input  logic [ADDR_WIDTH-1:0]              burst_addr,
    input  logic [ADDR_WIDTH-1:0]              burst_len,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] rd_data,
    output logic                               rd_valid,
    output logic                               burst_busy,
    output logic                               burst_done,
    output logic                               err
);

    localparam int DATA_WIDTH = MATRIX_WIDTH * BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   counter;
    logic [ADDR_WIDTH-1:0]   remaining;

    logic [DATA_WIDTH-1:0]   data_pipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_pipe;
    logic                    err_q;

    logic                    issue;
    logic                    start_burst;
    logic                    burst_step;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic                    issue_oob;
    logic [DATA_WIDTH-1:0]   read_row;
    logic                    last_issue;
    logic                    wr_oob;
    logic                    rd_drop;
    logic                    start_err;
    logic                    err_set;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_row(input logic [ADDR_WIDTH-1:0] a);
        return (({1'b0, a} + 1'b1) >= DEPTH_X) ? '0 : a + 1'b1;
    endfunction

    // Pick the read source for this cycle: burst counter has priority, then a
    // new burst, then a single-row read; nothing issues while stalled.
    always_comb begin
        issue       = 1'b0;
        start_burst = 1'b0;
        burst_step  = 1'b0;
        issue_addr  = rd_addr;
        if (enable) begin
            if (state == BURST) begin
                issue      = 1'b1;
                burst_step = 1'b1;
                issue_addr = counter;
            end else if (burst_start) begin
                issue       = 1'b1;
                start_burst = 1'b1;
                issue_addr  = burst_addr;
            end else if (rd_en) begin
                issue = 1'b1;
            end
        end
    end

    assign issue_oob  = ~in_range(issue_addr);
    assign read_row   = issue_oob ? '0 : mem[issue_addr];
    assign last_issue = (burst_step && remaining == '0) || (start_burst && burst_len == '0);
    assign wr_oob     = wr_en && !in_range(wr_addr);
    assign rd_drop    = rd_en && (state == BURST || burst_start);
    assign start_err  = burst_start && enable && (state == BURST);
    assign err_set    = wr_oob | rd_drop | start_err | (issue & issue_oob);

    // Byte-masked row write; independent of enable, blocked in reset and for
    // rows past the end of the array.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && in_range(wr_addr)) begin
            for (int unsigned b = 0; b < MATRIX_WIDTH; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Burst FSM. The start cycle already issues burst_addr, so the counter is
    // preloaded one row ahead; a zero-length burst completes without entering BURST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            remaining <= '0;
        end else if (start_burst) begin
            counter   <= next_row(burst_addr);
            remaining <= burst_len - 1'b1;
            if (burst_len != '0) begin
                state <= BURST;
            end
        end else if (burst_step) begin
            counter   <= next_row(counter);
            remaining <= remaining - 1'b1;
            if (remaining == '0) begin
                state <= IDLE;
            end
        end
    end

    // Read pipeline: every stage advances only on enabled cycles, so a stall
    // holds rd_data/rd_valid; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_pipe[i] <= '0;
            end
        end else if (enable) begin
            valid_pipe[0] <= issue;
            data_pipe[0]  <= read_row;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                data_pipe[i]  <= data_pipe[i-1];
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign rd_data    = data_pipe[READ_LATENCY-1];
    assign rd_valid   = valid_pipe[READ_LATENCY-1];
    assign burst_busy = (state == BURST);
    assign burst_done = last_issue & ~rst;
    assign err        = err_q;

endmodule

// File: tb/tb_weight_buffer_mb.sv
// tb_weight_buffer_mb: table-driven vectors plus hand-written burst sequences;
// read expectations go through a scoreboard queue keyed on enabled-cycle count.
module tb_weight_buffer_mb;

    localparam int MW    = 14;
    localparam int BW    = 8;
    localparam int DEPTH = 20;
    localparam int RL    = 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = MW * BW;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_mask;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          burst_start;
    logic [AW-1:0] burst_addr;
    logic [AW-1:0] burst_len;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          burst_busy;
    logic          burst_done;
    logic          err;

    weight_buffer_mb #(
        .MATRIX_WIDTH (MW),
        .BYTE_WIDTH   (BW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_mask     (wr_mask),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .burst_start (burst_start),
        .burst_addr  (burst_addr),
        .burst_len   (burst_len),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .burst_busy  (burst_busy),
        .burst_done  (burst_done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the expected status outputs.
    // ps/pa: this cycle issues a read of row pa (expected data pushed to queue).
    typedef struct {
        logic          rst;
        logic          en;
        logic          we;
        logic [AW-1:0] wa;
        logic [MW-1:0] wm;
        logic [7:0]    wf;
        logic          re;
        logic [AW-1:0] ra;
        logic          bs;
        logic [AW-1:0] ba;
        logic [AW-1:0] bl;
        logic          ps;
        logic [AW-1:0] pa;
        logic          done;
        logic          busy;
        logic          err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    sb_t           sb[$];
    vec_t          tbl[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            en_cnt;
    int            step_no;
    int            checks;
    int            failures;
    logic          prev_valid;
    logic [DW-1:0] prev_data;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%b expected=%b", name, step_no, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step_no, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_row(input logic [AW-1:0] a);
        if (32'(a) < DEPTH) return model_mem[a];
        return '0;
    endfunction

    function automatic vec_t nop(input logic busy, input logic e);
        vec_t v;
        v = '{1'b0, 1'b1, 1'b0, 5'd0, 14'h0, 8'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0,
              1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        v.busy = busy;
        v.err  = e;
        return v;
    endfunction

    function automatic vec_t bstep(input logic [AW-1:0] a, input logic done,
                                   input logic busy, input logic e);
        vec_t v;
        v      = nop(busy, e);
        v.ps   = 1'b1;
        v.pa   = a;
        v.done = done;
        return v;
    endfunction

    function automatic vec_t bstart(input logic [AW-1:0] a, input logic [AW-1:0] len,
                                    input logic busy, input logic e);
        vec_t v;
        v    = bstep(a, (len == '0), busy, e);
        v.bs = 1'b1;
        v.ba = a;
        v.bl = len;
        return v;
    endfunction

    function automatic vec_t rst_vec();
        vec_t v;
        v     = nop(1'b0, 1'b0);
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic run(input vec_t v);
        sb_t e;
        step_no++;
        rst         = v.rst;
        enable      = v.en;
        wr_en       = v.we;
        wr_addr     = v.wa;
        wr_mask     = v.wm;
        wr_data     = {MW{v.wf}};
        rd_en       = v.re;
        rd_addr     = v.ra;
        burst_start = v.bs;
        burst_addr  = v.ba;
        burst_len   = v.bl;
        #1;
        chk_bit("burst_done", burst_done, v.done);
        // read-first: expected data taken from the model before this cycle's write
        if (v.ps) begin
            e.data = model_row(v.pa);
            e.due  = en_cnt + RL;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v.rst) begin
            sb.delete();
            chk_bit("rst_rd_valid", rd_valid, 1'b0);
            chk_row("rst_rd_data", rd_data, '0);
        end else begin
            if (v.we && 32'(v.wa) < DEPTH) begin
                for (int b = 0; b < MW; b++) begin
                    if (v.wm[b]) model_mem[v.wa][b*BW +: BW] = v.wf;
                end
            end
            if (v.en) begin
                en_cnt++;
                if (sb.size() > 0 && sb[0].due == en_cnt) begin
                    e = sb.pop_front();
                    chk_bit("rd_valid", rd_valid, 1'b1);
                    chk_row("rd_data", rd_data, e.data);
                end else begin
                    chk_bit("rd_valid_idle", rd_valid, 1'b0);
                end
            end else begin
                chk_bit("hold_valid", rd_valid, prev_valid);
                chk_row("hold_data", rd_data, prev_data);
            end
        end
        chk_bit("burst_busy", burst_busy, v.busy);
        chk_bit("err", err, v.err);
        prev_valid = rd_valid;
        prev_data  = rd_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d simulation did not finish", step_no);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        checks     = 0;
        failures   = 0;
        step_no    = 0;
        en_cnt     = 0;
        prev_valid = 1'b0;
        prev_data  = '0;
        for (int r = 0; r < DEPTH; r++) model_mem[r] = '0;

        // reset state, then give every row a known value (row 7 stays zero)
        run(rst_vec());
        run(rst_vec());
        for (int r = 0; r < DEPTH; r++) begin
            v    = nop(1'b0, 1'b0);
            v.we = 1'b1;
            v.wa = 5'(r);
            v.wm = '1;
            v.wf = (r == 7) ? 8'h00 : 8'(r * 7 + 1);
            run(v);
        end

        //         rst   en    we    wa     wm        wf     re    ra     bs    ba     bl     ps    pa     done  busy  err
        tbl.push_back('{1'b0,1'b1,1'b1,5'd5, 14'h3fff,8'haa,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b1,5'd5, 1'b0,5'd0, 5'd0, 1'b1,5'd5, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,5'd5, 14'h0001,8'h11,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b1,5'd5, 1'b0,5'd0, 5'd0, 1'b1,5'd5, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,5'd7, 14'h3fff,8'h55,1'b1,5'd7, 1'b0,5'd0, 5'd0, 1'b1,5'd7, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b1,5'd7, 1'b0,5'd0, 5'd0, 1'b1,5'd7, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,5'd9, 14'h2001,8'h3c,1'b1,5'd9, 1'b0,5'd0, 5'd0, 1'b1,5'd9, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b1,5'd9, 1'b0,5'd0, 5'd0, 1'b1,5'd9, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b0,5'd0, 14'h0000,8'h00,1'b1,5'd3, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b1,5'd2, 5'd1, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b1,1'b1,1'b1,5'd2, 14'h3fff,8'hee,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b1,5'd2, 1'b0,5'd0, 5'd0, 1'b1,5'd2, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b1,5'd4, 5'd0, 1'b1,5'd4, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,5'd0, 14'h0000,8'h00,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,1'b0,1'b0});
        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // burst wrapping past the last row
        run(bstart(5'd18, 5'd3, 1'b1, 1'b0));
        run(bstep(5'd19, 1'b0, 1'b1, 1'b0));
        run(bstep(5'd0,  1'b0, 1'b1, 1'b0));
        run(bstep(5'd1,  1'b1, 1'b0, 1'b0));
        run(nop(1'b0, 1'b0));
        run(nop(1'b0, 1'b0));

        // three-cycle stall in the middle of a burst
        run(bstart(5'd10, 5'd4, 1'b1, 1'b0));
        run(bstep(5'd11, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            v    = nop(1'b1, 1'b0);
            v.en = 1'b0;
            run(v);
        end
        run(bstep(5'd12, 1'b0, 1'b1, 1'b0));
        run(bstep(5'd13, 1'b0, 1'b1, 1'b0));
        run(bstep(5'd14, 1'b1, 1'b0, 1'b0));
        run(nop(1'b0, 1'b0));
        run(nop(1'b0, 1'b0));

        // reset with two reads in flight, then confirm RAM survived
        run(bstart(5'd0, 5'd5, 1'b1, 1'b0));
        run(bstep(5'd1, 1'b0, 1'b1, 1'b0));
        run(rst_vec());
        run(nop(1'b0, 1'b0));
        v = nop(1'b0, 1'b0); v.re = 1'b1; v.ra = 5'd0; v.ps = 1'b1; v.pa = 5'd0; run(v);
        v = nop(1'b0, 1'b0); v.re = 1'b1; v.ra = 5'd1; v.ps = 1'b1; v.pa = 5'd1; run(v);
        run(nop(1'b0, 1'b0));
        run(nop(1'b0, 1'b0));

        // out-of-range write
        v = nop(1'b0, 1'b1); v.we = 1'b1; v.wa = 5'd25; v.wm = '1; v.wf = 8'h77; run(v);
        run(rst_vec());

        // out-of-range read returns zeros with rd_valid
        v = nop(1'b0, 1'b1); v.re = 1'b1; v.ra = 5'd22; v.ps = 1'b1; v.pa = 5'd22; run(v);
        run(nop(1'b0, 1'b1));
        run(rst_vec());

        // rd_en during a burst is dropped
        run(bstart(5'd3, 5'd2, 1'b1, 1'b0));
        v = bstep(5'd4, 1'b0, 1'b1, 1'b1); v.re = 1'b1; v.ra = 5'd8; run(v);
        run(bstep(5'd5, 1'b1, 1'b0, 1'b1));
        run(nop(1'b0, 1'b1));
        run(nop(1'b0, 1'b1));
        run(rst_vec());

        // rd_en together with burst_start is dropped
        v = bstart(5'd6, 5'd0, 1'b0, 1'b1); v.re = 1'b1; v.ra = 5'd9; run(v);
        run(nop(1'b0, 1'b1));
        run(rst_vec());

        // burst_start while busy is ignored
        run(bstart(5'd12, 5'd1, 1'b1, 1'b0));
        v = bstep(5'd13, 1'b1, 1'b0, 1'b1); v.bs = 1'b1; v.ba = 5'd2; v.bl = 5'd0; run(v);
        run(nop(1'b0, 1'b1));
        run(rst_vec());
        run(nop(1'b0, 1'b0));
        run(nop(1'b0, 1'b0));

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain step=%0d got=%0d expected=0 pending reads", step_no, sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
